dma_prio_arb: RTL and testbench
===============================

DMA_PRIO_ARB -- requirements
Module: dma_prio_arb

Interface
REQ-001 Parameter: NUM_CH, 4, number of DMA channels (2..8).
REQ-002 Parameter: CH_W, $clog2(NUM_CH), width of the channel index.
REQ-003 Port: CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: RESET  input  1  reset, asynchronous, active-high.
REQ-005 Port: DREQ  input  NUM_CH  channel requests, already synchronous to CLK.
REQ-006 Port: DREQ_SENSE  input  1  0 = DREQ active-high, 1 = active-low.
REQ-007 Port: MASK  input  NUM_CH  1 = channel masked, request ignored.
REQ-008 Port: ROT_PRI  input  1  0 = fixed priority, 1 = rotating priority.
REQ-009 Port: HLDA  input  1  hold acknowledge from the CPU.
REQ-010 Port: TC  input  1  terminal-count pulse for the active channel.
REQ-011 Port: EOP_N  input  1  external end-of-process, active-low.
REQ-012 Port: HRQ  output  1  hold request to the CPU, registered.
REQ-013 Port: DACK  output  NUM_CH  one-hot grant, active-high, registered.
REQ-014 Port: ACTIVE_CH  output  CH_W  index of the granted channel; valid while GNT_VALID = 1.
REQ-015 Port: GNT_VALID  output  1  high while in state GRANT.

Function
REQ-016 The effective request vector SHALL be (DREQ XOR {NUM_CH{DREQ_SENSE}}) AND NOT MASK.
REQ-017 The FSM SHALL have exactly four states: IDLE, HOLD, GRANT, RELEASE.
REQ-018 IDLE->HOLD SHALL occur at an edge where any effective request = 1 and HLDA = 0; HRQ = 1 from that edge on.
REQ-019 HOLD->GRANT SHALL occur at an edge where HLDA = 1 and an effective request exists. At that edge the winner SHALL be chosen, DACK[winner] = 1, ACTIVE_CH = winner and GNT_VALID = 1.
REQ-020 HOLD->RELEASE SHALL occur if all effective requests are gone at the edge where HLDA = 1, or before it; HRQ = 0 from that edge on.
REQ-021 GRANT->RELEASE SHALL occur at an edge sampling TC = 1 or EOP_N = 0. DACK, GNT_VALID and HRQ SHALL be 0 from that edge on.
REQ-022 GRANT->IDLE SHALL occur if HLDA = 0 is sampled (CPU abort); DACK, GNT_VALID and HRQ SHALL clear at that same edge.
REQ-023 RESET->IDLE SHALL occur at the first edge with HLDA = 0, so that no new HRQ is raised before the CPU has released HLDA.
REQ-024 ACTIVE_CH and DACK SHALL stay frozen for the whole of GRANT; changes to DREQ or MASK during GRANT SHALL be ignored.
REQ-025 Fixed mode: channel 0 is the highest priority and NUM_CH-1 the lowest.
REQ-026 Rotating mode: a priority pointer P marks the highest-priority channel, with priority descending P, P+1, ... modulo NUM_CH.
REQ-027 When GRANT ends via TC or EOP_N, P SHALL be set to (ACTIVE_CH+1) mod NUM_CH, wrapping NUM_CH-1 -> 0.
REQ-028 P SHALL NOT update on a CPU abort or while ROT_PRI = 0.
REQ-029 Latency: effective request to HRQ = 1 cycle; HLDA high to DACK = 1 cycle; TC to DACK low = 1 cycle.
REQ-030 TC and EOP_N together SHALL be treated as a single termination.

Reset
REQ-031 While RESET = 1 the block SHALL hold: state IDLE, HRQ = 0, DACK = 0, ACTIVE_CH = 0, GNT_VALID = 0, P = 0, and SW_REQ_Q = 0 when that register is present.
REQ-032 Reset asserted mid-GRANT SHALL clear DACK and HRQ immediately, without waiting for a clock edge.

Configuration
REQ-033 Macro DMA_ARB_SW_REQ_EN SHALL control software requests.
- Defined: add input SW_REQ_SET (NUM_CH) and register SW_REQ_Q. A set bit is latched. It is ORed into the effective request and bypasses MASK and DREQ_SENSE. The granted channel's bit clears on TC or EOP_N.
- Undefined: none of these ports or registers exist, and the behaviour is exactly as specified above.

Structure
REQ-034 Package dma_arb_pkg SHALL hold the FSM state enum (arb_state_e) and the NUM_CH upper-bound constant DMA_MAX_CH = 8.
REQ-035 Sub-module dma_prio_sel SHALL be combinational. It takes the request vector, P and ROT_PRI, and returns a winner index plus an any-request flag.

Verification
REQ-036 Fixed mode, DREQ = 4'b1010, MASK = 0, HLDA raised 2 cycles after HRQ -> DACK = 4'b0010 and ACTIVE_CH = 1; TC pulse -> HRQ = 0 next cycle.
REQ-037 Rotating mode: grant channel 2, end with TC, then DREQ = 4'b1111 -> next DACK = 4'b1000 (P = 3); after that TC -> next grant goes to channel 0.
REQ-038 DREQ = 4'b0100 with MASK = 4'b0100 -> HRQ stays 0 for 10 cycles; clearing MASK -> HRQ = 1 one cycle later.
REQ-039 DREQ_SENSE = 1, DREQ = 4'b1110 -> channel 0 requests; DACK = 4'b0001 after HLDA.
REQ-040 HLDA dropped mid-GRANT -> DACK = 0 at that edge, P unchanged; RESET pulsed mid-GRANT -> all outputs 0 asynchronously.
REQ-041 With DMA_ARB_SW_REQ_EN defined: SW_REQ_SET = 4'b0001 with MASK = 4'b0001 -> channel 0 granted; after TC, SW_REQ_Q = 0.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and limits for the DMA priority arbiter.
// Optional software requests are enabled by defining DMA_ARB_SW_REQ_EN.
package dma_arb_pkg;

    localparam int DMA_MAX_CH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/dma_prio_sel.sv
// Combinational priority picker: fixed (channel 0 first) or rotating from ptr.
module dma_prio_sel
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              rot_pri,
    output logic [CH_W-1:0]   winner,
    output logic              any_req
);

    localparam int SUM_W = CH_W + 1;

    logic [CH_W-1:0] base_s;

    assign base_s  = rot_pri ? ptr : {CH_W{1'b0}};
    assign any_req = |req;

    // Walk from lowest to highest priority so the last requesting hit wins.
    always_comb begin
        logic [CH_W:0] pos_v;
        winner = {CH_W{1'b0}};
        pos_v  = {SUM_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            pos_v  = {1'b0, base_s} + SUM_W'(i);
            pos_v  = (pos_v >= SUM_W'(NUM_CH)) ? (pos_v - SUM_W'(NUM_CH)) : pos_v;
            winner = req[pos_v[CH_W-1:0]] ? pos_v[CH_W-1:0] : winner;
        end
    end

endmodule

// File: rtl/dma_prio_arb.sv
// DMA channel arbiter: hold request/acknowledge handshake with fixed or rotating priority.
// Define DMA_ARB_SW_REQ_EN to add latched software requests (SW_REQ_SET).
module dma_prio_arb
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              DREQ_SENSE,
    input  logic [NUM_CH-1:0] MASK,
    input  logic              ROT_PRI,
    input  logic              HLDA,
    input  logic              TC,
    input  logic              EOP_N,
`ifdef DMA_ARB_SW_REQ_EN
    input  logic [NUM_CH-1:0] SW_REQ_SET,
`endif
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic [CH_W-1:0]   ACTIVE_CH,
    output logic              GNT_VALID
);

    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    arb_state_e        state_q, state_d;
    logic              hrq_q, hrq_d;
    logic [NUM_CH-1:0] dack_q, dack_d;
    logic [CH_W-1:0]   active_ch_q, active_ch_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;

    logic [NUM_CH-1:0] eff_req_s;
    logic [CH_W-1:0]   winner_s;
    logic [CH_W-1:0]   ptr_next_s;
    logic              any_req_s;
    logic              term_s;

    assign term_s     = TC | ~EOP_N;
    assign ptr_next_s = (active_ch_q == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}}
                                                            : (active_ch_q + CH_W'(1));

`ifdef DMA_ARB_SW_REQ_EN
    logic [NUM_CH-1:0] sw_req_q, sw_req_d;
    logic [NUM_CH-1:0] sw_clr_s;

    // Software requests ignore MASK and DREQ_SENSE.
    assign eff_req_s = ((DREQ ^ {NUM_CH{DREQ_SENSE}}) & ~MASK) | sw_req_q;

    // Latch new software requests; retire the granted one on normal termination.
    always_comb begin
        sw_clr_s = {NUM_CH{1'b0}};
        if ((state_q == GRANT) && HLDA && term_s) begin
            sw_clr_s = ONE_HOT0 << active_ch_q;
        end else begin
            sw_clr_s = {NUM_CH{1'b0}};
        end
        sw_req_d = (sw_req_q & ~sw_clr_s) | SW_REQ_SET;
    end

    // Software request register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sw_req_q <= {NUM_CH{1'b0}};
        end else begin
            sw_req_q <= sw_req_d;
        end
    end
`else
    assign eff_req_s = (DREQ ^ {NUM_CH{DREQ_SENSE}}) & ~MASK;
`endif

    dma_prio_sel #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_sel (
        .req     (eff_req_s),
        .ptr     (ptr_q),
        .rot_pri (ROT_PRI),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    // Next-state and registered-output logic of the hold/grant handshake.
    always_comb begin
        state_d     = state_q;
        hrq_d       = hrq_q;
        dack_d      = dack_q;
        active_ch_d = active_ch_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        case (state_q)
            IDLE: begin
                // Holding off while HLDA is still high keeps a fresh HRQ from racing the CPU.
                if (any_req_s && !HLDA) begin
                    state_d = HOLD;
                    hrq_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (!any_req_s) begin
                    state_d = RELEASE;
                    hrq_d   = 1'b0;
                end else if (HLDA) begin
                    state_d     = GRANT;
                    dack_d      = ONE_HOT0 << winner_s;
                    active_ch_d = winner_s;
                    gnt_valid_d = 1'b1;
                end else begin
                    state_d = HOLD;
                end
            end
            GRANT: begin
                // A CPU abort wins over a coincident termination and leaves P alone.
                if (!HLDA) begin
                    state_d     = IDLE;
                    hrq_d       = 1'b0;
                    dack_d      = {NUM_CH{1'b0}};
                    gnt_valid_d = 1'b0;
                end else if (term_s) begin
                    state_d     = RELEASE;
                    hrq_d       = 1'b0;
                    dack_d      = {NUM_CH{1'b0}};
                    gnt_valid_d = 1'b0;
                    ptr_d       = ROT_PRI ? ptr_next_s : ptr_q;
                end else begin
                    state_d = GRANT;
                end
            end
            RELEASE: begin
                hrq_d       = 1'b0;
                dack_d      = {NUM_CH{1'b0}};
                gnt_valid_d = 1'b0;
                state_d     = HLDA ? RELEASE : IDLE;
            end
            default: begin
                state_d     = IDLE;
                hrq_d       = 1'b0;
                dack_d      = {NUM_CH{1'b0}};
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            hrq_q       <= 1'b0;
            dack_q      <= {NUM_CH{1'b0}};
            active_ch_q <= {CH_W{1'b0}};
            gnt_valid_q <= 1'b0;
            ptr_q       <= {CH_W{1'b0}};
        end else begin
            state_q     <= state_d;
            hrq_q       <= hrq_d;
            dack_q      <= dack_d;
            active_ch_q <= active_ch_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign HRQ       = hrq_q;
    assign DACK      = dack_q;
    assign ACTIVE_CH = active_ch_q;
    assign GNT_VALID = gnt_valid_q;

endmodule

// File: tb/tb_dma_prio_arb.sv
// Scoreboard bench for dma_prio_arb: directed scenarios queue expected grants, a monitor checks them.
module tb_dma_prio_arb;

    logic       CLK;
    logic       RESET;
    logic [3:0] DREQ;
    logic       DREQ_SENSE;
    logic [3:0] MASK;
    logic       ROT_PRI;
    logic       HLDA;
    logic       TC;
    logic       EOP_N;
`ifdef DMA_ARB_SW_REQ_EN
    logic [3:0] SW_REQ_SET;
`endif
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] ACTIVE_CH;
    logic       GNT_VALID;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] exp_dack_q[$];
    logic [1:0] exp_ch_q[$];

    dma_prio_arb #(.NUM_CH(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .DREQ       (DREQ),
        .DREQ_SENSE (DREQ_SENSE),
        .MASK       (MASK),
        .ROT_PRI    (ROT_PRI),
        .HLDA       (HLDA),
        .TC         (TC),
        .EOP_N      (EOP_N),
`ifdef DMA_ARB_SW_REQ_EN
        .SW_REQ_SET (SW_REQ_SET),
`endif
        .HRQ        (HRQ),
        .DACK       (DACK),
        .ACTIVE_CH  (ACTIVE_CH),
        .GNT_VALID  (GNT_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic expect_grant(input logic [3:0] d, input logic [1:0] c);
        exp_dack_q.push_back(d);
        exp_ch_q.push_back(c);
    endtask

    // Monitor: pop the scoreboard on each new grant, check the grant stays frozen afterwards.
    initial begin
        logic       prev_gnt;
        logic [3:0] held_dack;
        logic [1:0] held_ch;
        prev_gnt  = 1'b0;
        held_dack = 4'b0000;
        held_ch   = 2'd0;
        forever begin
            @(negedge CLK);
            if (GNT_VALID === 1'b1 && prev_gnt !== 1'b1) begin
                if (exp_dack_q.size() == 0) begin
                    chk("unexpected_grant", {4'h0, DACK}, 8'h00);
                end else begin
                    chk("grant_dack", {4'h0, DACK}, {4'h0, exp_dack_q.pop_front()});
                    chk("grant_ch", {6'h0, ACTIVE_CH}, {6'h0, exp_ch_q.pop_front()});
                end
                held_dack = DACK;
                held_ch   = ACTIVE_CH;
            end else if (GNT_VALID === 1'b1) begin
                chk("frozen_dack", {4'h0, DACK}, {4'h0, held_dack});
                chk("frozen_ch", {6'h0, ACTIVE_CH}, {6'h0, held_ch});
            end
            prev_gnt = GNT_VALID;
        end
    end

    // term: 0 = TC, 1 = EOP_N, 2 = both at once.
    task automatic grant_cycle(input logic rot, input logic [3:0] dreq, input logic [3:0] mask,
                               input int extra_wait, input int term,
                               input logic [3:0] exp_d, input logic [1:0] exp_c);
        ROT_PRI = rot;
        DREQ    = dreq;
        MASK    = mask;
        expect_grant(exp_d, exp_c);
        cyc(1);
        chk("hrq_rise", {7'h0, HRQ}, 8'h01);
        cyc(extra_wait);
        chk("no_grant_before_hlda", {7'h0, GNT_VALID}, 8'h00);
        HLDA = 1'b1;
        cyc(1);
        chk("gnt_valid", {7'h0, GNT_VALID}, 8'h01);
        DREQ = ~dreq;
        MASK = 4'b0000;
        cyc(2);
        TC    = (term != 1);
        EOP_N = (term == 0);
        cyc(1);
        chk("term_hrq", {7'h0, HRQ}, 8'h00);
        chk("term_dack", {4'h0, DACK}, 8'h00);
        chk("term_gnt", {7'h0, GNT_VALID}, 8'h00);
        TC    = 1'b0;
        EOP_N = 1'b1;
        HLDA  = 1'b0;
        DREQ  = DREQ_SENSE ? 4'b1111 : 4'b0000;
        cyc(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET      = 1'b1;
        DREQ       = 4'b0000;
        DREQ_SENSE = 1'b0;
        MASK       = 4'b0000;
        ROT_PRI    = 1'b0;
        HLDA       = 1'b0;
        TC         = 1'b0;
        EOP_N      = 1'b1;
`ifdef DMA_ARB_SW_REQ_EN
        SW_REQ_SET = 4'b0000;
`endif
        cyc(2);
        chk("rst_hrq", {7'h0, HRQ}, 8'h00);
        chk("rst_dack", {4'h0, DACK}, 8'h00);
        chk("rst_ch", {6'h0, ACTIVE_CH}, 8'h00);
        chk("rst_gnt", {7'h0, GNT_VALID}, 8'h00);
        RESET = 1'b0;
        cyc(1);

        // Fixed priority, HLDA two cycles after HRQ.
        grant_cycle(1'b0, 4'b1010, 4'b0000, 1, 0, 4'b0010, 2'd1);

        // Request withdrawn while waiting for HLDA.
        DREQ = 4'b0001;
        cyc(1);
        chk("cancel_hrq_rise", {7'h0, HRQ}, 8'h01);
        DREQ = 4'b0000;
        cyc(1);
        chk("cancel_hrq_drop", {7'h0, HRQ}, 8'h00);
        cyc(2);

        // Rotating: 2, then P=3 gives 3, then P=0 gives 0.
        grant_cycle(1'b1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 2'd2);
        grant_cycle(1'b1, 4'b1111, 4'b0000, 0, 1, 4'b1000, 2'd3);
        grant_cycle(1'b1, 4'b1111, 4'b0000, 0, 2, 4'b0001, 2'd0);

        // Masked request never raises HRQ.
        ROT_PRI = 1'b0;
        DREQ    = 4'b0100;
        MASK    = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("masked_hrq", {7'h0, HRQ}, 8'h00);
        end
        grant_cycle(1'b0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 2'd2);

        // Active-low sense.
        DREQ_SENSE = 1'b1;
        DREQ       = 4'b1111;
        cyc(1);
        chk("sense_idle_hrq", {7'h0, HRQ}, 8'h00);
        grant_cycle(1'b0, 4'b1110, 4'b0000, 0, 1, 4'b0001, 2'd0);
        DREQ_SENSE = 1'b0;
        DREQ       = 4'b0000;
        cyc(1);

        // CPU abort: P stays at 1, so the retry also goes to channel 1.
        ROT_PRI = 1'b1;
        DREQ    = 4'b1111;
        expect_grant(4'b0010, 2'd1);
        cyc(1);
        chk("abort_hrq_rise", {7'h0, HRQ}, 8'h01);
        HLDA = 1'b1;
        cyc(1);
        chk("abort_gnt", {7'h0, GNT_VALID}, 8'h01);
        HLDA = 1'b0;
        cyc(1);
        chk("abort_dack", {4'h0, DACK}, 8'h00);
        chk("abort_hrq", {7'h0, HRQ}, 8'h00);
        chk("abort_gnt_low", {7'h0, GNT_VALID}, 8'h00);
        expect_grant(4'b0010, 2'd1);
        cyc(1);
        chk("retry_hrq", {7'h0, HRQ}, 8'h01);
        HLDA = 1'b1;
        cyc(1);
        chk("retry_gnt", {7'h0, GNT_VALID}, 8'h01);

        // Asynchronous reset in the middle of a grant.
        #1 RESET = 1'b1;
        #1;
        chk("async_dack", {4'h0, DACK}, 8'h00);
        chk("async_hrq", {7'h0, HRQ}, 8'h00);
        chk("async_gnt", {7'h0, GNT_VALID}, 8'h00);
        chk("async_ch", {6'h0, ACTIVE_CH}, 8'h00);
        HLDA = 1'b0;
        DREQ = 4'b0000;
        cyc(1);
        RESET = 1'b0;
        cyc(1);

        // Pointer back at 0 after reset.
        grant_cycle(1'b1, 4'b1111, 4'b0000, 0, 0, 4'b0001, 2'd0);

`ifdef DMA_ARB_SW_REQ_EN
        // Software request bypasses MASK and clears on TC.
        ROT_PRI    = 1'b0;
        MASK       = 4'b0001;
        DREQ       = 4'b0000;
        SW_REQ_SET = 4'b0001;
        expect_grant(4'b0001, 2'd0);
        cyc(1);
        SW_REQ_SET = 4'b0000;
        cyc(1);
        chk("sw_hrq", {7'h0, HRQ}, 8'h01);
        HLDA = 1'b1;
        cyc(1);
        chk("sw_gnt", {7'h0, GNT_VALID}, 8'h01);
        TC = 1'b1;
        cyc(1);
        TC   = 1'b0;
        HLDA = 1'b0;
        chk("sw_req_cleared", {4'h0, dut.sw_req_q}, 8'h00);
        cyc(3);
        chk("sw_no_rerequest", {7'h0, HRQ}, 8'h00);
        MASK = 4'b0000;
`endif

        cyc(2);
        chk("scoreboard_drained", 8'(exp_dack_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
